// File: rtl/actor_if_multi.sv
// Context-addressed multi-channel actor write driver with freshness gating,
// actor-ID collision arbitration and sync-credit back-pressure.
module actor_if_multi #(
    parameter int unsigned CONTEXT_ADDR_WIDTH = 8,
    parameter int unsigned CONTEXT_SIZE       = 256,
    parameter int unsigned CHANNELS           = 2,
    parameter int unsigned ACTOR_ID_WIDTH     = 4,
    parameter int unsigned PE_ID_WIDTH        = 5,
    parameter int unsigned MAX_PENDING_SYNCS  = 4,
    localparam int unsigned SLOT_W = ACTOR_ID_WIDTH + PE_ID_WIDTH + 2,
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned PEND_W = $clog2(MAX_PENDING_SYNCS + 1)
) (
    input  logic                                CGRA_CLK_I,
    input  logic                                RST_I,
    input  logic                                EN_I,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]       CCNT_I,
    input  logic                                CONTEXT_WRITE_EN_I,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]       CONTEXT_ADDR_I,
    input  logic [CH_W-1:0]                     CONTEXT_CHANNEL_I,
    input  logic [SLOT_W-1:0]                   CONTEXT_DATA_I,
    output logic [CHANNELS*ACTOR_ID_WIDTH-1:0]  ACTOR_WRITE_ADDR_O,
    output logic [CHANNELS*PE_ID_WIDTH-1:0]     ACTOR_SOURCE_PE_ID_O,
    output logic [CHANNELS-1:0]                 ACTOR_WRITE_ENABLE_O,
    output logic                                SYNC_OUT_O,
    output logic [PEND_W-1:0]                   SYNC_PENDING_O,
    input  logic                                SYNC_ACK_I,
    output logic                                STALL_O,
    output logic                                COLLISION_O,
    output logic                                OVERFLOW_O,
    input  logic                                CLEAR_ERR_I
);

    localparam int unsigned WE_BIT   = ACTOR_ID_WIDTH + PE_ID_WIDTH;
    localparam int unsigned SYNC_BIT = SLOT_W - 1;

    logic [SLOT_W-1:0] mem [CONTEXT_SIZE][CHANNELS];

    logic [SLOT_W-1:0] ctx_q [CHANNELS];
    logic [SLOT_W-1:0] ctx_d [CHANNELS];
    logic              fresh_q, fresh_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              coll_q, coll_d;
    logic              ovf_q, ovf_d;

    logic wr_addr_ok, rd_addr_ok, wr_ch_ok, wr_en;

    // Range guards only exist when the index space is wider than the storage.
    if (CONTEXT_SIZE == (1 << CONTEXT_ADDR_WIDTH)) begin : g_addr_full
        assign wr_addr_ok = 1'b1;
        assign rd_addr_ok = 1'b1;
    end else begin : g_addr_part
        assign wr_addr_ok = CONTEXT_ADDR_I < CONTEXT_ADDR_WIDTH'(CONTEXT_SIZE);
        assign rd_addr_ok = CCNT_I < CONTEXT_ADDR_WIDTH'(CONTEXT_SIZE);
    end

    if (CHANNELS == (1 << CH_W)) begin : g_ch_full
        assign wr_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign wr_ch_ok = CONTEXT_CHANNEL_I < CH_W'(CHANNELS);
    end

    assign wr_en = CONTEXT_WRITE_EN_I & EN_I & wr_addr_ok & wr_ch_ok;

    // Memory is deliberately outside reset so contents survive RST_I.
    always_ff @(posedge CGRA_CLK_I) begin
        if (wr_en) begin
            mem[CONTEXT_ADDR_I][CONTEXT_CHANNEL_I] <= CONTEXT_DATA_I;
        end
    end

    always_comb begin
        fresh_d = EN_I;
        for (int i = 0; i < CHANNELS; i++) begin
            ctx_d[i] = ctx_q[i];
            if (EN_I) begin
                ctx_d[i] = rd_addr_ok ? mem[CCNT_I][i] : '0;
            end
        end
    end

    logic [CHANNELS-1:0]       raw_we;
    logic [CHANNELS-1:0]       supp;
    logic [CHANNELS-1:0]       slot_sync;
    logic [ACTOR_ID_WIDTH-1:0] aid [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            aid[i]       = ctx_q[i][ACTOR_ID_WIDTH-1:0];
            raw_we[i]    = fresh_q & ctx_q[i][WE_BIT];
            slot_sync[i] = ctx_q[i][SYNC_BIT];
        end
        // Lowest enabled channel wins an actor ID; higher duplicates are dropped.
        for (int i = 0; i < CHANNELS; i++) begin
            supp[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (raw_we[i] && raw_we[j] && (aid[i] == aid[j])) begin
                    supp[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_out
        assign ACTOR_WRITE_ADDR_O[i*ACTOR_ID_WIDTH +: ACTOR_ID_WIDTH] = aid[i];
        assign ACTOR_SOURCE_PE_ID_O[i*PE_ID_WIDTH +: PE_ID_WIDTH] =
            ctx_q[i][ACTOR_ID_WIDTH +: PE_ID_WIDTH];
    end

    logic sync_evt, pend_full;

    assign ACTOR_WRITE_ENABLE_O = raw_we & ~supp;
    assign sync_evt             = fresh_q & (|slot_sync);
    assign pend_full            = pend_q >= PEND_W'(MAX_PENDING_SYNCS);

    always_comb begin
        pend_d = pend_q;
        if (sync_evt && !SYNC_ACK_I) begin
            if (!pend_full) begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!sync_evt && SYNC_ACK_I && (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
        // A new set in the same cycle as a clear must survive.
        coll_d = (|supp) | (coll_q & ~CLEAR_ERR_I);
        ovf_d  = (sync_evt & ~SYNC_ACK_I & pend_full) | (ovf_q & ~CLEAR_ERR_I);
    end

    always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ctx_q[i] <= '0;
            end
            fresh_q <= 1'b0;
            pend_q  <= '0;
            coll_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            fresh_q <= fresh_d;
            pend_q  <= pend_d;
            coll_q  <= coll_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SYNC_OUT_O     = sync_evt;
    assign SYNC_PENDING_O = pend_q;
    assign STALL_O        = pend_full;
    assign COLLISION_O    = coll_q;
    assign OVERFLOW_O     = ovf_q;

endmodule

// File: tb/tb_actor_if_multi.sv
// Directed bench for actor_if_multi with default parameters (2 channels, 4 credits).
module tb_actor_if_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  ccnt;
    logic        cwe;
    logic [7:0]  caddr;
    logic [0:0]  cch;
    logic [10:0] cdata;
    logic [7:0]  waddr;
    logic [9:0]  pe;
    logic [1:0]  we;
    logic        sync_out;
    logic [2:0]  pend;
    logic        ack;
    logic        stall;
    logic        coll;
    logic        ovf;
    logic        clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    actor_if_multi dut (
        .CGRA_CLK_I          (clk),
        .RST_I               (rst),
        .EN_I                (en),
        .CCNT_I              (ccnt),
        .CONTEXT_WRITE_EN_I  (cwe),
        .CONTEXT_ADDR_I      (caddr),
        .CONTEXT_CHANNEL_I   (cch),
        .CONTEXT_DATA_I      (cdata),
        .ACTOR_WRITE_ADDR_O  (waddr),
        .ACTOR_SOURCE_PE_ID_O(pe),
        .ACTOR_WRITE_ENABLE_O(we),
        .SYNC_OUT_O          (sync_out),
        .SYNC_PENDING_O      (pend),
        .SYNC_ACK_I          (ack),
        .STALL_O             (stall),
        .COLLISION_O         (coll),
        .OVERFLOW_O          (ovf),
        .CLEAR_ERR_I         (clr)
    );

    function automatic logic [10:0] mk(input logic s, input logic w, input logic [4:0] p,
                                       input logic [3:0] a);
        return {s, w, p, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] row, input logic ch, input logic [10:0] d);
        en = 1'b1; cwe = 1'b1; caddr = row; cch = ch; cdata = d;
        tick();
        cwe = 1'b0;
    endtask

    task automatic test_reset();
        // Preload rows while held in reset; row 0 is the neutral idle row.
        ccnt = 8'd0;
        wr(8'd0, 1'b0, 11'd0);
        wr(8'd0, 1'b1, 11'd0);
        wr(8'd4, 1'b0, mk(1'b0, 1'b1, 5'd1, 4'd4));
        wr(8'd4, 1'b1, mk(1'b0, 1'b1, 5'd2, 4'd4));
        wr(8'd5, 1'b0, mk(1'b1, 1'b0, 5'd0, 4'd0));
        wr(8'd5, 1'b1, mk(1'b1, 1'b0, 5'd0, 4'd0));
        wr(8'd6, 1'b0, mk(1'b0, 1'b1, 5'd3, 4'd1));
        wr(8'd6, 1'b1, 11'd0);
        n_checks++;
        if ({waddr, pe, we, sync_out, pend, stall, coll, ovf} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {waddr, pe, we, sync_out, pend, stall, coll, ovf});
        end
        en = 1'b0;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        ccnt = 8'd0;
        wr(8'd3, 1'b0, mk(1'b0, 1'b1, 5'd5, 4'd2));
        wr(8'd3, 1'b1, mk(1'b1, 1'b1, 5'd7, 4'd9));
        en = 1'b1; ccnt = 8'd3;
        tick();
        n_checks++;
        if (we !== 2'b11 || sync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_we_sync: got we=%b sync=%b required we=11 sync=1", we, sync_out);
        end
        n_checks++;
        if (waddr !== 8'h92 || pe !== {5'd7, 5'd5}) begin
            n_fail++;
            $display("FAIL basic_fields: got addr=%h pe=%h required addr=92 pe=%h",
                     waddr, pe, {5'd7, 5'd5});
        end
        n_checks++;
        if (pend !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_pend_latency: got %0d required 0", pend);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({we, sync_out, waddr, pe, pend} !== {2'b00, 1'b0, 8'h92, 5'd7, 5'd5, 3'd1}) begin
                n_fail++;
                $display("FAIL hold_%0d: got we=%b sync=%b addr=%h pe=%h pend=%0d required we=00 sync=0 addr=92 pe=%h pend=1",
                         i, we, sync_out, waddr, pe, pend, {5'd7, 5'd5});
            end
        end
    endtask

    task automatic test_collision();
        en = 1'b1; ccnt = 8'd4;
        tick();
        n_checks++;
        if (we !== 2'b01 || waddr !== 8'h44 || coll !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_arb: got we=%b addr=%h coll=%b required we=01 addr=44 coll=0",
                     we, waddr, coll);
        end
        en = 1'b0; clr = 1'b1;
        tick();
        n_checks++;
        if (coll !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_set_beats_clear: got %b required 1", coll);
        end
        clr = 1'b0;
        tick();
        n_checks++;
        if (coll !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_sticky: got %b required 1", coll);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (coll !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_clear: got %b required 0", coll);
        end
    endtask

    task automatic test_rw_same_row();
        en = 1'b1; ccnt = 8'd6; cwe = 1'b1; caddr = 8'd6; cch = 1'b0;
        cdata = mk(1'b0, 1'b1, 5'd4, 4'd3);
        tick();
        cwe = 1'b0;
        n_checks++;
        if (waddr !== 8'h01 || pe !== {5'd0, 5'd3}) begin
            n_fail++;
            $display("FAIL rw_old_data: got addr=%h pe=%h required addr=01 pe=%h",
                     waddr, pe, {5'd0, 5'd3});
        end
        en = 1'b0; cwe = 1'b1; cch = 1'b1; cdata = mk(1'b0, 1'b1, 5'd9, 4'd8);
        tick();
        cwe = 1'b0; en = 1'b1;
        tick();
        n_checks++;
        if (waddr !== 8'h03 || pe !== {5'd0, 5'd4} || we !== 2'b01) begin
            n_fail++;
            $display("FAIL rw_new_data_write_gated: got addr=%h pe=%h we=%b required addr=03 pe=%h we=01",
                     waddr, pe, we, {5'd0, 5'd4});
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        int exp_p;
        ack = 1'b1;
        tick();
        n_checks++;
        if (pend !== 3'd0) begin
            n_fail++;
            $display("FAIL ack_decrement: got %0d required 0", pend);
        end
        tick();
        ack = 1'b0;
        n_checks++;
        if (pend !== 3'd0) begin
            n_fail++;
            $display("FAIL ack_at_zero: got %0d required 0", pend);
        end
        for (int k = 1; k <= 5; k++) begin
            en = 1'b1; ccnt = 8'd5;
            tick();
            en = 1'b0;
            n_checks++;
            if (sync_out !== 1'b1 || we !== 2'b00) begin
                n_fail++;
                $display("FAIL sync_event_%0d: got sync=%b we=%b required sync=1 we=00", k, sync_out, we);
            end
            tick();
            exp_p = (k < 4) ? k : 4;
            n_checks++;
            if (pend !== 3'(exp_p) || stall !== (k >= 4) || ovf !== (k == 5)) begin
                n_fail++;
                $display("FAIL credit_%0d: got pend=%0d stall=%b ovf=%b required pend=%0d stall=%b ovf=%b",
                         k, pend, stall, ovf, exp_p, (k >= 4), (k == 5));
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pend !== 3'd3 || stall !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_unstall: got pend=%0d stall=%b ovf=%b required pend=3 stall=0 ovf=1",
                     pend, stall, ovf);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        en = 1'b1; ccnt = 8'd5;
        tick();
        en = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pend !== 3'd2) begin
            n_fail++;
            $display("FAIL event_with_ack: got %0d required 2", pend);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b required 0", ovf);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; ccnt = 8'd3;
        tick();
        n_checks++;
        if (we !== 2'b11 || pend !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: got we=%b pend=%0d required we=11 pend=2", we, pend);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({waddr, pe, we, sync_out, pend, stall, coll, ovf} !== 27'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0",
                     {waddr, pe, we, sync_out, pend, stall, coll, ovf});
        end
        en = 1'b0;
        #3 rst = 1'b0;
        tick();
        en = 1'b1; ccnt = 8'd3;
        tick();
        en = 1'b0;
        n_checks++;
        if (waddr !== 8'h92 || pe !== {5'd7, 5'd5} || we !== 2'b11 || sync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL memory_retained: got addr=%h pe=%h we=%b sync=%b required addr=92 pe=%h we=11 sync=1",
                     waddr, pe, we, sync_out, {5'd7, 5'd5});
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ccnt = 8'd0; cwe = 1'b0; caddr = 8'd0; cch = 1'b0;
        cdata = 11'd0; ack = 1'b0; clr = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_collision();
        test_rw_same_row();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
